// File: rtl/ex_stage_if.sv
// ID/EX bundle, forwarding/hazard controls and EX/MEM results of the execute stage.
// The master side drives the ID/EX inputs; the slave side is the execute stage itself.
interface ex_stage_if #(
    parameter int XLEN = 32
);
    logic            valid_e;
    logic [2:0]      alu_control_e;
    logic            alu_src_e;
    logic [XLEN-1:0] rd1_e;
    logic [XLEN-1:0] rd2_e;
    logic [XLEN-1:0] imm_e;
    logic [XLEN-1:0] pc_e;
    logic [XLEN-1:0] pc_plus4_e;
    logic [4:0]      rd_e;
    logic            reg_write_e;
    logic            mem_write_e;
    logic            branch_e;
    logic            jump_e;
    logic [1:0]      result_src_e;
    logic [1:0]      forward_a_e;
    logic [1:0]      forward_b_e;
    logic [XLEN-1:0] result_w;
    logic            stall_m;
    logic            flush_m;

    logic            pc_src_e;
    logic [XLEN-1:0] pc_target_e;
    logic            zero_e;
    logic [XLEN-1:0] alu_result_m;
    logic [XLEN-1:0] write_data_m;
    logic [XLEN-1:0] pc_plus4_m;
    logic [4:0]      rd_m;
    logic            reg_write_m;
    logic            mem_write_m;
    logic            valid_m;
    logic [1:0]      result_src_m;

    modport master (
        output valid_e, alu_control_e, alu_src_e, rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e,
               rd_e, reg_write_e, mem_write_e, branch_e, jump_e, result_src_e,
               forward_a_e, forward_b_e, result_w, stall_m, flush_m,
        input  pc_src_e, pc_target_e, zero_e, alu_result_m, write_data_m, pc_plus4_m,
               rd_m, reg_write_m, mem_write_m, valid_m, result_src_m
    );

    modport slave (
        input  valid_e, alu_control_e, alu_src_e, rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e,
               rd_e, reg_write_e, mem_write_e, branch_e, jump_e, result_src_e,
               forward_a_e, forward_b_e, result_w, stall_m, flush_m,
        output pc_src_e, pc_target_e, zero_e, alu_result_m, write_data_m, pc_plus4_m,
               rd_m, reg_write_m, mem_write_m, valid_m, result_src_m
    );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register with stall and flush.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);

    // Forwarding select; the unused 2'b11 code falls back to the register file.
    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf_val,
        input logic [XLEN-1:0] wb_val,
        input logic [XLEN-1:0] mem_val
    );
        logic [XLEN-1:0] res;
        case (sel)
            2'b01:   res = wb_val;
            2'b10:   res = mem_val;
            default: res = rf_val;
        endcase
        return res;
    endfunction

    function automatic logic [XLEN-1:0] alu(
        input logic [2:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] res;
        case (op)
            3'b000:  res = a + b;
            3'b001:  res = a - b;
            3'b010:  res = a & b;
            3'b011:  res = a | b;
            3'b101:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    logic [XLEN-1:0] src_a_s;
    logic [XLEN-1:0] fwd_b_s;
    logic [XLEN-1:0] src_b_s;
    logic [XLEN-1:0] alu_result_s;
    logic            zero_s;
    logic            pc_src_s;
    logic [XLEN-1:0] pc_target_s;

    logic [XLEN-1:0] alu_result_r;
    logic [XLEN-1:0] write_data_r;
    logic [XLEN-1:0] pc_plus4_r;
    logic [4:0]      rd_r;
    logic            reg_write_r;
    logic            mem_write_r;
    logic            valid_r;
    logic [1:0]      result_src_r;

    // Operand selection, ALU and redirect decision.
    always_comb begin
        src_a_s      = {XLEN{1'b0}};
        fwd_b_s      = {XLEN{1'b0}};
        src_b_s      = {XLEN{1'b0}};
        alu_result_s = {XLEN{1'b0}};
        zero_s       = 1'b0;
        pc_src_s     = 1'b0;
        pc_target_s  = {XLEN{1'b0}};

        // alu_result_r is the live register, so a value held by a stall still forwards.
        src_a_s = fwd_mux(bus.forward_a_e, bus.rd1_e, bus.result_w, alu_result_r);
        fwd_b_s = fwd_mux(bus.forward_b_e, bus.rd2_e, bus.result_w, alu_result_r);
        if (bus.alu_src_e) begin
            src_b_s = bus.imm_e;
        end else begin
            src_b_s = fwd_b_s;
        end

        alu_result_s = alu(bus.alu_control_e, src_a_s, src_b_s);
        zero_s       = (alu_result_s == {XLEN{1'b0}});
        pc_target_s  = bus.pc_e + bus.imm_e;
        pc_src_s     = bus.valid_e & ((bus.branch_e & zero_s) | bus.jump_e);
    end

    // EX/MEM register: flush squashes side effects and beats stall; data fields hold on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_r <= {XLEN{1'b0}};
            write_data_r <= {XLEN{1'b0}};
            pc_plus4_r   <= {XLEN{1'b0}};
            rd_r         <= 5'd0;
            reg_write_r  <= 1'b0;
            mem_write_r  <= 1'b0;
            valid_r      <= 1'b0;
            result_src_r <= 2'b00;
        end else if (bus.flush_m) begin
            reg_write_r  <= 1'b0;
            mem_write_r  <= 1'b0;
            valid_r      <= 1'b0;
        end else if (!bus.stall_m) begin
            alu_result_r <= alu_result_s;
            write_data_r <= fwd_b_s;
            pc_plus4_r   <= bus.pc_plus4_e;
            rd_r         <= bus.rd_e;
            reg_write_r  <= bus.reg_write_e & bus.valid_e;
            mem_write_r  <= bus.mem_write_e & bus.valid_e;
            valid_r      <= bus.valid_e;
            result_src_r <= bus.result_src_e;
        end else begin
            alu_result_r <= alu_result_r;
            write_data_r <= write_data_r;
            pc_plus4_r   <= pc_plus4_r;
            rd_r         <= rd_r;
            reg_write_r  <= reg_write_r;
            mem_write_r  <= mem_write_r;
            valid_r      <= valid_r;
            result_src_r <= result_src_r;
        end
    end

    assign bus.pc_src_e     = pc_src_s;
    assign bus.pc_target_e  = pc_target_s;
    assign bus.zero_e       = zero_s;
    assign bus.alu_result_m = alu_result_r;
    assign bus.write_data_m = write_data_r;
    assign bus.pc_plus4_m   = pc_plus4_r;
    assign bus.rd_m         = rd_r;
    assign bus.reg_write_m  = reg_write_r;
    assign bus.mem_write_m  = mem_write_r;
    assign bus.valid_m      = valid_r;
    assign bus.result_src_m = result_src_r;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage with hand-computed expectations.
module tb_ex_stage;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ex_stage_if #(.XLEN(32)) bus ();

    ex_stage #(.XLEN(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, leaving time for the registers to settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.valid_e       = 1'b1;
        bus.alu_control_e = 3'b000;
        bus.alu_src_e     = 1'b0;
        bus.rd1_e         = 32'd0;
        bus.rd2_e         = 32'd0;
        bus.imm_e         = 32'd0;
        bus.pc_e          = 32'd0;
        bus.pc_plus4_e    = 32'd4;
        bus.rd_e          = 5'd1;
        bus.reg_write_e   = 1'b1;
        bus.mem_write_e   = 1'b0;
        bus.branch_e      = 1'b0;
        bus.jump_e        = 1'b0;
        bus.result_src_e  = 2'b00;
        bus.forward_a_e   = 2'b00;
        bus.forward_b_e   = 2'b00;
        bus.result_w      = 32'd0;
        bus.stall_m       = 1'b0;
        bus.flush_m       = 1'b0;
    endtask

    task automatic check_all_m_zero(input string tag);
        check_val({tag, "_alu"}, bus.alu_result_m, 32'd0);
        check_val({tag, "_wd"},  bus.write_data_m, 32'd0);
        check_val({tag, "_pc4"}, bus.pc_plus4_m,   32'd0);
        check_val({tag, "_rd"},  {27'd0, bus.rd_m}, 32'd0);
        check_val({tag, "_rw"},  {31'd0, bus.reg_write_m}, 32'd0);
        check_val({tag, "_mw"},  {31'd0, bus.mem_write_m}, 32'd0);
        check_val({tag, "_vm"},  {31'd0, bus.valid_m}, 32'd0);
        check_val({tag, "_rs"},  {30'd0, bus.result_src_m}, 32'd0);
    endtask

    logic [2:0]  op_tab  [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    logic [31:0] exp_tab [5] = '{32'd10, 32'd4, 32'd3, 32'd7, 32'd0};

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_idle();
        #23;
        check_all_m_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // ALU ops on 7 and 3
        for (int i = 0; i < 5; i++) begin
            set_idle();
            bus.rd1_e         = 32'd7;
            bus.rd2_e         = 32'd3;
            bus.alu_control_e = op_tab[i];
            step();
            check_val($sformatf("alu_op%0d", i), bus.alu_result_m, exp_tab[i]);
        end
        check_val("store_data_rf", bus.write_data_m, 32'd3);
        check_val("valid_m_live", {31'd0, bus.valid_m}, 32'd1);

        bus.rd1_e         = 32'hFFFF_FFFF;
        bus.rd2_e         = 32'd1;
        bus.alu_control_e = 3'b101;
        bus.pc_plus4_e    = 32'h0000_0124;
        bus.result_src_e  = 2'b10;
        bus.rd_e          = 5'd13;
        step();
        check_val("slt_signed", bus.alu_result_m, 32'd1);
        check_val("pc4_pass", bus.pc_plus4_m, 32'h0000_0124);
        check_val("rsrc_pass", {30'd0, bus.result_src_m}, 32'd2);
        check_val("rd_pass", {27'd0, bus.rd_m}, 32'd13);

        bus.alu_control_e = 3'b110;
        bus.rd1_e         = 32'd7;
        bus.rd2_e         = 32'd3;
        #1;
        check_val("undef_op_zero", {31'd0, bus.zero_e}, 32'd1);
        step();
        check_val("undef_op_res", bus.alu_result_m, 32'd0);

        // Forwarding
        set_idle();
        bus.rd1_e = 32'h100;
        step();
        check_val("fwd_setup", bus.alu_result_m, 32'h100);
        bus.rd1_e       = 32'd5;
        bus.rd2_e       = 32'd77;
        bus.result_w    = 32'h20;
        bus.forward_a_e = 2'b10;
        bus.forward_b_e = 2'b01;
        step();
        check_val("fwd_mem_wb", bus.alu_result_m, 32'h120);
        check_val("fwd_wd", bus.write_data_m, 32'h20);
        bus.forward_a_e = 2'b11;
        step();
        check_val("fwd_a_11", bus.alu_result_m, 32'h25);

        // Branch resolution
        set_idle();
        bus.rd1_e         = 32'd9;
        bus.rd2_e         = 32'd9;
        bus.alu_control_e = 3'b001;
        bus.branch_e      = 1'b1;
        bus.pc_e          = 32'h40;
        bus.imm_e         = 32'hFFFF_FFF0;
        #1;
        check_val("beq_taken", {31'd0, bus.pc_src_e}, 32'd1);
        check_val("beq_target", bus.pc_target_e, 32'h30);
        bus.rd2_e = 32'd8;
        #1;
        check_val("beq_not_taken", {31'd0, bus.pc_src_e}, 32'd0);
        bus.rd2_e   = 32'd9;
        bus.valid_e = 1'b0;
        #1;
        check_val("beq_bubble", {31'd0, bus.pc_src_e}, 32'd0);
        step();
        check_val("bubble_valid_m", {31'd0, bus.valid_m}, 32'd0);
        check_val("bubble_rw_m", {31'd0, bus.reg_write_m}, 32'd0);
        bus.valid_e  = 1'b1;
        bus.branch_e = 1'b0;
        bus.jump_e   = 1'b1;
        bus.rd2_e    = 32'd8;
        #1;
        check_val("jump_taken", {31'd0, bus.pc_src_e}, 32'd1);

        // Stall holds the register, and forwarding sees the held value
        set_idle();
        bus.rd1_e = 32'h55;
        bus.rd2_e = 32'd1;
        bus.rd_e  = 5'd7;
        step();
        check_val("stall_setup", bus.alu_result_m, 32'h56);
        bus.stall_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.rd1_e       = 32'd100 + 32'(i);
            bus.rd_e        = 5'd20 + 5'(i);
            bus.reg_write_e = i[0];
            bus.forward_a_e = 2'b10;
            bus.alu_src_e   = 1'b1;
            bus.imm_e       = 32'hFFFF_FFAA;
            #1;
            check_val($sformatf("stall_fwd_zero%0d", i), {31'd0, bus.zero_e}, 32'd1);
            step();
            check_val($sformatf("stall_alu%0d", i), bus.alu_result_m, 32'h56);
            check_val($sformatf("stall_rd%0d", i), {27'd0, bus.rd_m}, 32'd7);
            check_val($sformatf("stall_rw%0d", i), {31'd0, bus.reg_write_m}, 32'd1);
        end

        // Flush beats stall
        bus.reg_write_e = 1'b1;
        bus.mem_write_e = 1'b1;
        bus.flush_m     = 1'b1;
        step();
        check_val("flush_rw", {31'd0, bus.reg_write_m}, 32'd0);
        check_val("flush_mw", {31'd0, bus.mem_write_m}, 32'd0);
        check_val("flush_vm", {31'd0, bus.valid_m}, 32'd0);

        // Store with forwarded data and immediate address
        set_idle();
        bus.rd1_e = 32'hAB;
        step();
        check_val("sw_setup", bus.alu_result_m, 32'hAB);
        bus.rd1_e       = 32'h1000;
        bus.rd2_e       = 32'h5;
        bus.alu_src_e   = 1'b1;
        bus.imm_e       = 32'd8;
        bus.forward_b_e = 2'b10;
        bus.mem_write_e = 1'b1;
        bus.reg_write_e = 1'b0;
        step();
        check_val("sw_addr", bus.alu_result_m, 32'h1008);
        check_val("sw_data", bus.write_data_m, 32'hAB);
        check_val("sw_mw", {31'd0, bus.mem_write_m}, 32'd1);
        check_val("sw_rw", {31'd0, bus.reg_write_m}, 32'd0);

        // Asynchronous reset mid-cycle
        set_idle();
        bus.rd1_e = 32'h33;
        step();
        check_val("pre_reset_rw", {31'd0, bus.reg_write_m}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_m_zero("async_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage RV32I pipeline. It consumes the ID/EX bundle, including the 3-bit ALU control code from the ALU decoder, and selects forwarded operands. It computes the ALU result, resolves branches and jumps, and registers the results into the EX/MEM pipeline register with stall and flush support.

Parameters:
XLEN, 32, datapath width in bits (operands, results, PC).

Ports:
clk  in  1  pipeline clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
valid_e  in  1  ID/EX slot holds a live instruction.
alu_control_e  in  3  ALU op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
alu_src_e  in  1  1 = operand B is imm_e; 0 = forwarded rs2 value.
rd1_e, rd2_e  in  XLEN  register-file read data (rs1, rs2).
imm_e  in  XLEN  sign-extended immediate.
pc_e, pc_plus4_e  in  XLEN  instruction PC and PC+4.
rd_e  in  5  destination register.
reg_write_e, mem_write_e, branch_e, jump_e  in  1  control bits.
result_src_e  in  2  writeback select, passed through.
forward_a_e, forward_b_e  in  2  00 = register file, 01 = result_w, 10 = alu_result_m; 11 is treated as 00.
result_w  in  XLEN  writeback-stage result.
stall_m  in  1  hold the EX/MEM register.
flush_m  in  1  squash the instruction entering EX/MEM.
pc_src_e  out  1  redirect fetch (combinational).
pc_target_e  out  XLEN  branch/jump target pc_e + imm_e (combinational).
zero_e  out  1  ALU result == 0 (combinational).
alu_result_m, write_data_m, pc_plus4_m  out  XLEN  registered EX/MEM data.
rd_m  out  5  registered destination.
reg_write_m, mem_write_m, valid_m  out  1  registered control.
result_src_m  out  2  registered writeback select.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: all `_m` outputs are 0 while rst_n = 0, applied asynchronously, including mid-operation.
- Reset exit: the first capture happens on the first rising clk edge after rst_n rises.
- Operand A: mux(forward_a_e) over {rd1_e, result_w, alu_result_m}.
- Forwarded B: mux(forward_b_e) over the same three sources.
- Operand B: alu_src_e ? imm_e : forwarded B.
- ALU ADD/SUB: modulo 2^XLEN, overflow ignored.
- ALU AND/OR: bitwise.
- ALU SLT: signed compare; result is {XLEN-1 zeros, (A <s B)}.
- ALU codes 100, 110, 111: result 0.
- zero_e: asserted when the ALU result is all zeros.
- pc_src_e = valid_e & ((branch_e & zero_e) | jump_e). It is never asserted when valid_e = 0.
- pc_target_e = pc_e + imm_e, modulo 2^XLEN.
- Pipeline latency: 1 cycle. Values computed at edge N appear on the `_m` outputs after edge N.
- write_data_m captures the forwarded B value, never imm_e.
- Normal edge (stall_m = 0, flush_m = 0): capture all `_m` fields.
- Control qualification: reg_write_m, mem_write_m and valid_m each capture their `_e` value ANDed with valid_e, so a bubble carries no side effects.
- Stall (stall_m = 1, flush_m = 0): all `_m` registers hold their values.
- Flush (flush_m = 1): reg_write_m, mem_write_m and valid_m clear to 0; data fields may capture or hold.
- Flush has priority over stall.
- Forwarding from alu_result_m uses the current registered value, including a value held by a stall.

Test Plan:
- Reset: assert rst_n = 0 mid-run with reg_write_m = 1 -> every `_m` output reads 0 immediately, before any clock edge.
- ALU ops: rd1 = 7, rd2 = 3, forward = 00, alu_src = 0; codes 000/001/010/011/101 -> alu_result_m = 10 / 4 / 3 / 7 / 0 one cycle later. rd1 = 0xFFFFFFFF, rd2 = 1, SLT -> 1.
- Forwarding: alu_result_m = 0x100, result_w = 0x20, rd1 = 5; forward_a = 10, forward_b = 01, ADD -> 0x120. forward_a = 11 -> uses rd1 = 5.
- Branches: beq with rd1 = rd2 = 9, SUB, branch = 1, pc = 0x40, imm = 0xFFFFFFF0 -> pc_src_e = 1 and pc_target_e = 0x30. rd2 = 8 -> pc_src_e = 0. Same case with valid_e = 0 -> pc_src_e = 0 and valid_m = 0 next cycle.
- Stall and flush: stall_m = 1 for 3 cycles with changing inputs -> `_m` outputs constant. stall_m = 1 and flush_m = 1 together with reg_write_e = mem_write_e = 1 -> reg_write_m = mem_write_m = valid_m = 0.
- Store data: sw with alu_src = 1, imm = 8, rd1 = 0x1000, forward_b = 10 and alu_result_m = 0xAB -> alu_result_m = 0x1008, write_data_m = 0xAB, mem_write_m = 1.
